// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: PC register, branch redirect and IF/ID pipeline register
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc_plus4,
  input  logic [15:0] branch_offset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_data,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic [15:0] fetch_count
);

  localparam logic [31:0] WRAP_ADDR  = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic        if_valid_q, if_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4;
  logic [31:0] seq_next;
  logic [31:0] branch_target;

  assign pc_plus4      = pc_q + 32'd4;
  assign seq_next      = (pc_plus4 == WRAP_ADDR) ? 32'd0 : pc_plus4;
  assign branch_target = branch_pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};

  always_comb begin
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc_plus4_d = if_pc_plus4_q;
    if_valid_d    = if_valid_q;
    fetch_count_d = fetch_count_q;
    if (branch_taken) begin
      // Redirect squashes the word fetched this cycle into a NOP bubble.
      pc_d          = {branch_target[31:2], 2'b00};
      if_instr_d    = 32'h0;
      if_pc_plus4_d = 32'h0;
      if_valid_d    = 1'b0;
    end else if (!stall) begin
      pc_d          = seq_next;
      if_instr_d    = imem_data;
      if_pc_plus4_d = pc_plus4;
      if_valid_d    = 1'b1;
      if (fetch_count_q != 16'hFFFF) begin
        fetch_count_d = fetch_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_ADDR;
      if_instr_q    <= 32'h0;
      if_pc_plus4_q <= 32'h0;
      if_valid_q    <= 1'b0;
      fetch_count_q <= 16'h0;
    end else begin
      pc_q          <= pc_d;
      if_instr_q    <= if_instr_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      if_valid_q    <= if_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_address = pc_q;
  assign if_instr     = if_instr_q;
  assign if_pc_plus4  = if_pc_plus4_q;
  assign if_valid     = if_valid_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_pc_plus4 = 32'h0;
  logic [15:0] branch_offset = 16'h0;
  logic [31:0] imem_address;
  logic [31:0] imem_data;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic [15:0] fetch_count;

  logic [31:0] mem [0:31];
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_address[6:2]];

  instruction_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(32)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
    .branch_pc_plus4(branch_pc_plus4), .branch_offset(branch_offset),
    .imem_address(imem_address), .imem_data(imem_data), .if_instr(if_instr),
    .if_pc_plus4(if_pc_plus4), .if_valid(if_valid), .fetch_count(fetch_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    total++; if (imem_address !== 32'h0) $display("FAIL reset_pc got=%h exp=0", imem_address); else passed++;
    total++; if (if_instr !== 32'h0) $display("FAIL reset_instr got=%h exp=0", if_instr); else passed++;
    total++; if (if_pc_plus4 !== 32'h0) $display("FAIL reset_pcp4 got=%h exp=0", if_pc_plus4); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", if_valid); else passed++;
    total++; if (fetch_count !== 16'h0) $display("FAIL reset_count got=%h exp=0", fetch_count); else passed++;
    step();
    #1 reset_n = 1'b1;
    total++; if (imem_address !== 32'h0) $display("FAIL reset_hold_pc got=%h exp=0", imem_address); else passed++;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      step();
      total++; if (imem_address !== 32'(i * 4)) $display("FAIL seq_addr%0d got=%h exp=%h", i, imem_address, 32'(i * 4)); else passed++;
    end
    total++; if (if_instr !== mem[3]) $display("FAIL seq_instr got=%h exp=%h", if_instr, mem[3]); else passed++;
    total++; if (if_pc_plus4 !== 32'd16) $display("FAIL seq_pcp4 got=%h exp=10", if_pc_plus4); else passed++;
    total++; if (fetch_count !== 16'd4) $display("FAIL seq_count got=%0d exp=4", fetch_count); else passed++;
    total++; if (if_valid !== 1'b1) $display("FAIL seq_valid got=%b exp=1", if_valid); else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (imem_address !== 32'd8) $display("FAIL stall_pc%0d got=%h exp=8", i, imem_address); else passed++;
      total++; if (if_instr !== mem[1]) $display("FAIL stall_instr%0d got=%h exp=%h", i, if_instr, mem[1]); else passed++;
      total++; if (fetch_count !== 16'd2) $display("FAIL stall_count%0d got=%0d exp=2", i, fetch_count); else passed++;
    end
    stall = 1'b0;
    step();
    total++; if (if_instr !== mem[2]) $display("FAIL stall_release_instr got=%h exp=%h", if_instr, mem[2]); else passed++;
    total++; if (imem_address !== 32'd12) $display("FAIL stall_release_pc got=%h exp=c", imem_address); else passed++;
    total++; if (fetch_count !== 16'd3) $display("FAIL stall_release_count got=%0d exp=3", fetch_count); else passed++;
  endtask

  task automatic test_branch();
    branch_taken = 1'b1;
    branch_pc_plus4 = 32'd24;
    branch_offset = 16'h0005;
    step();
    branch_taken = 1'b0;
    total++; if (imem_address !== 32'd44) $display("FAIL br_pc got=%h exp=2c", imem_address); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL br_valid got=%b exp=0", if_valid); else passed++;
    total++; if (if_instr !== 32'h0) $display("FAIL br_instr got=%h exp=0", if_instr); else passed++;
    total++; if (if_pc_plus4 !== 32'h0) $display("FAIL br_pcp4 got=%h exp=0", if_pc_plus4); else passed++;
    total++; if (fetch_count !== 16'd3) $display("FAIL br_count got=%0d exp=3", fetch_count); else passed++;
    step();
    total++; if (if_instr !== mem[11]) $display("FAIL br_target_instr got=%h exp=%h", if_instr, mem[11]); else passed++;
    total++; if (if_valid !== 1'b1) $display("FAIL br_target_valid got=%b exp=1", if_valid); else passed++;
    total++; if (if_pc_plus4 !== 32'd48) $display("FAIL br_target_pcp4 got=%h exp=30", if_pc_plus4); else passed++;
  endtask

  task automatic test_branch_stall();
    branch_taken = 1'b1;
    stall = 1'b1;
    branch_pc_plus4 = 32'd20;
    branch_offset = 16'hFFFE;
    step();
    branch_taken = 1'b0;
    stall = 1'b0;
    total++; if (imem_address !== 32'd12) $display("FAIL brst_pc got=%h exp=c", imem_address); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL brst_valid got=%b exp=0", if_valid); else passed++;
    total++; if (fetch_count !== 16'd4) $display("FAIL brst_count got=%0d exp=4", fetch_count); else passed++;
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1;
    branch_pc_plus4 = 32'd124;
    branch_offset = 16'h0000;
    step();
    branch_taken = 1'b0;
    total++; if (imem_address !== 32'd124) $display("FAIL wrap_setup_pc got=%h exp=7c", imem_address); else passed++;
    step();
    total++; if (imem_address !== 32'd0) $display("FAIL wrap_pc got=%h exp=0", imem_address); else passed++;
    total++; if (if_pc_plus4 !== 32'd128) $display("FAIL wrap_pcp4 got=%h exp=80", if_pc_plus4); else passed++;
    total++; if (if_instr !== mem[31]) $display("FAIL wrap_instr got=%h exp=%h", if_instr, mem[31]); else passed++;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 65534; i++) step();
    total++; if (fetch_count !== 16'hFFFE) $display("FAIL sat_pre got=%h exp=fffe", fetch_count); else passed++;
    step();
    total++; if (fetch_count !== 16'hFFFF) $display("FAIL sat_max got=%h exp=ffff", fetch_count); else passed++;
    for (int i = 0; i < 3; i++) step();
    total++; if (fetch_count !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", fetch_count); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    step();
    branch_taken = 1'b1;
    branch_pc_plus4 = 32'd40;
    branch_offset = 16'h0000;
    step();
    total++; if (imem_address !== 32'd40) $display("FAIL areset_setup_pc got=%h exp=28", imem_address); else passed++;
    stall = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    total++; if (imem_address !== 32'h0) $display("FAIL areset_pc got=%h exp=0", imem_address); else passed++;
    total++; if (fetch_count !== 16'h0) $display("FAIL areset_count got=%h exp=0", fetch_count); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL areset_valid got=%b exp=0", if_valid); else passed++;
    #1 reset_n = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    step();
    total++; if (if_instr !== mem[0]) $display("FAIL areset_first_instr got=%h exp=%h", if_instr, mem[0]); else passed++;
    total++; if (imem_address !== 32'd4) $display("FAIL areset_first_pc got=%h exp=4", imem_address); else passed++;
    total++; if (fetch_count !== 16'd1) $display("FAIL areset_first_count got=%0d exp=1", fetch_count); else passed++;
    total++; if (if_pc_plus4 !== 32'd4) $display("FAIL areset_first_pcp4 got=%h exp=4", if_pc_plus4); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = {16'hC0DE, 16'(i * 3 + 1)};
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'h0000_0000, meaning the byte address fetched first after reset.
REQ-002 The block SHALL take parameter IMEM_WORDS, default 32, meaning the instruction memory depth in 32-bit words; sequential fetch wraps at IMEM_WORDS*4.
REQ-003 The block SHALL provide port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL provide port reset_n, input, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
REQ-005 The block SHALL provide port stall, input, 1: hold PC and the IF/ID register this cycle.
REQ-006 The block SHALL provide port branch_taken, input, 1: redirect the fetch this cycle.
REQ-007 The block SHALL provide port branch_pc_plus4, input, 32: PC+4 of the branching instruction.
REQ-008 The block SHALL provide port branch_offset, input, 16: the signed word offset from the branch immediate field.
REQ-009 The block SHALL provide port imem_address, output, 32: byte address to instruction memory; combinational, equal to pc.
REQ-010 The block SHALL provide port imem_data, input, 32: instruction word returned combinationally for imem_address.
REQ-011 The block SHALL provide port if_instr, output, 32: registered instruction to decode.
REQ-012 The block SHALL provide port if_pc_plus4, output, 32: registered PC+4 of if_instr.
REQ-013 The block SHALL provide port if_valid, output, 1: the IF/ID register holds a real instruction.
REQ-014 The block SHALL provide port fetch_count, output, 16: number of instructions accepted into IF/ID, saturating at 16'hFFFF.

Function
REQ-015 pc SHALL be a 32-bit register, and imem_address SHALL equal pc with no added latency.
REQ-016 seq_next SHALL be pc+4; when pc+4 equals IMEM_WORDS*4, seq_next SHALL be 0 (wrap).
REQ-017 branch_target SHALL be branch_pc_plus4 + (sign-extended branch_offset << 2), computed modulo 2^32 with no wrap-to-zero applied.
REQ-018 Priority on each rising edge SHALL be: branch_taken, then stall, then normal fetch.
REQ-019 Normal fetch (branch_taken=0, stall=0): pc <= seq_next; if_instr <= imem_data; if_pc_plus4 <= pc+4 (unwrapped); if_valid <= 1; fetch_count increments.
REQ-020 Stall (branch_taken=0, stall=1): pc, if_instr, if_pc_plus4, if_valid and fetch_count SHALL all hold.
REQ-021 Branch (branch_taken=1, regardless of stall): pc <= branch_target; if_instr <= 32'h0 (NOP, ADD R0,R0,R0); if_pc_plus4 <= 0; if_valid <= 0; fetch_count holds.
REQ-022 Fetch-to-decode latency SHALL be exactly 1 cycle: a word presented at imem_data appears on if_instr after the next rising edge.
REQ-023 A branch SHALL cost exactly one bubble, and the instruction at branch_target SHALL appear on if_instr 2 edges after the edge that samples branch_taken=1.
REQ-024 fetch_count SHALL saturate at 16'hFFFF and never wrap.
REQ-025 pc[1:0] SHALL always be 2'b00, and RESET_PC SHALL be word-aligned.

Reset
REQ-026 reset_n=0 SHALL immediately, without waiting for clk, set pc=RESET_PC, if_instr=0, if_pc_plus4=0, if_valid=0 and fetch_count=0.
REQ-027 Reset asserted mid-stall or mid-branch SHALL discard all pending state, and the first edge after deassertion SHALL perform a normal fetch from RESET_PC.

Verification
REQ-028 Reset then 4 free-running edges with a 32-word memory loaded: imem_address sequence 0,4,8,12,16; after the 4th edge, if_instr=mem[3], if_pc_plus4=16, fetch_count=4.
REQ-029 Stall held for 3 edges at pc=8: pc stays 8, if_instr holds mem[1], fetch_count unchanged; after release, the next edge loads mem[2].
REQ-030 branch_taken=1, branch_pc_plus4=24, branch_offset=16'h0005 (BEQ +5): next pc=44, if_valid=0, if_instr=0; the following edge gives if_instr=mem[11], if_valid=1.
REQ-031 branch_offset=16'hFFFE, branch_pc_plus4=20: pc=12; branch_taken and stall asserted together: the branch wins and pc=12.
REQ-032 pc=124 with IMEM_WORDS=32: next pc=0 and if_pc_plus4=128; fetch_count preset near 16'hFFFF saturates at 16'hFFFF.
REQ-033 reset_n pulsed low between edges while pc=40: outputs clear asynchronously, and the first edge after release fetches address 0.
